// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : ALUControl opcodes and sequencer states shared by the ALU files.
// Revision: 1.0
// ============================================================================
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_NOR   = 4'b1100,
    ALU_MUL   = 4'b1000,
    ALU_DIVU  = 4'b1001,
    ALU_REMU  = 4'b1010
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module  : alu_comb
// Brief   : Combinational single-cycle ALU slice; unknown codes yield zero.
// Revision: 1.0
// ============================================================================
module alu_comb
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   alu_control,
  output logic [N-1:0] y
);

  always_comb begin
    y = '0;
    case (alu_control)
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_PASSB: y = b;
      ALU_NOR:   y = ~(a | b);
      default:   y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
// Module  : alu_iter
// Brief   : Registered LEGv8 ALU with iterative multiply behind start/done;
//           define ALU_DIV_EN to include the unsigned divide/remainder unit.
// Revision: 1.0
// ============================================================================
module alu_iter
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero
);

  localparam int              CNT_W      = $clog2(N);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N - 1);

  alu_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic [N-1:0]     r_opa;     // multiplicand (MUL) or divisor (DIV)
  logic [N-1:0]     r_opb;     // multiplier (MUL) or dividend->quotient (DIV)
  logic [N-1:0]     r_acc;     // product accumulator or partial remainder
  logic [N-1:0]     r_result;
  logic             r_busy;
  logic             r_done;

  logic [N-1:0]     w_comb;
  logic [N-1:0]     w_mul_acc;
  logic [N-1:0]     w_iter_result;

  alu_comb #(.N(N)) u_comb (
    .a           (a),
    .b           (b),
    .alu_control (ALUControl),
    .y           (w_comb)
  );

  assign w_mul_acc = r_acc + (r_opb[0] ? r_opa : '0);

`ifdef ALU_DIV_EN
  logic [N:0]   w_rem_sh;
  logic [N:0]   w_diff;
  logic         w_qbit;
  logic [N-1:0] w_rem_next;
  logic [N-1:0] w_quo_next;
  logic         w_div_req;

  // Restoring step: bring in the next dividend bit, subtract if it fits.
  assign w_rem_sh   = {r_acc, r_opb[N-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opa};
  assign w_qbit     = ~w_diff[N];
  assign w_rem_next = w_qbit ? w_diff[N-1:0] : w_rem_sh[N-1:0];
  assign w_quo_next = {r_opb[N-2:0], w_qbit};
  assign w_div_req  = (ALUControl == ALU_DIVU) || (ALUControl == ALU_REMU);

  always_comb begin
    w_iter_result = w_mul_acc;
    if (r_op == ALU_DIVU)
      w_iter_result = w_quo_next;
    else if (r_op == ALU_REMU)
      w_iter_result = w_rem_next;
  end
`else
  always_comb begin
    w_iter_result = w_mul_acc;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_ITER: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_op == ALU_MUL) begin
            r_acc <= w_mul_acc;
            r_opa <= r_opa << 1;
            r_opb <= r_opb >> 1;
          end
`ifdef ALU_DIV_EN
          else begin
            r_acc <= w_rem_next;
            r_opb <= w_quo_next;
          end
`endif
          if (r_cnt == '0) begin
            r_result <= w_iter_result;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
        end

        default: begin
          // IDLE and DONE both accept; a request in DONE runs back-to-back.
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
          if (start) begin
            r_op <= ALUControl;
            if (ALUControl == ALU_MUL) begin
              r_opa   <= a;
              r_opb   <= b;
              r_acc   <= '0;
              r_cnt   <= C_CNT_LAST;
              r_busy  <= 1'b1;
              r_state <= ST_ITER;
            end
`ifdef ALU_DIV_EN
            else if (w_div_req && (b != '0)) begin
              r_opa   <= b;
              r_opb   <= a;
              r_acc   <= '0;
              r_cnt   <= C_CNT_LAST;
              r_busy  <= 1'b1;
              r_state <= ST_ITER;
            end else if (w_div_req) begin
              r_result <= (ALUControl == ALU_DIVU) ? '1 : a;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end
`endif
            else begin
              r_result <= w_comb;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end
          end
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign zero   = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_iter
// Brief   : Self-checking bench for alu_iter against an arithmetic reference.
// Revision: 1.0
// ============================================================================
module tb_alu_iter;

  localparam int N   = 64;
  localparam int TMO = 200;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   alu_control;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         zero;

  int           n_pass  = 0;
  int           n_total = 0;
  int           lat;
  int           busy_cycles;
  logic         overlap;
  logic         res_moved;
  logic [N-1:0] prev_res;

  always #5 clk = ~clk;

  alu_iter #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .ALUControl (alu_control),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero)
  );

  function automatic logic [N-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [N-1:0] ref_result(input logic [3:0] op,
                                              input logic [N-1:0] x,
                                              input logic [N-1:0] y);
    case (op)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd6:  return x - y;
      4'd7:  return y;
      4'd12: return ~(x | y);
      4'd8:  return x * y;
      4'd9:  return !DIV_EN ? '0 : (y == 0) ? '1 : x / y;
      4'd10: return !DIV_EN ? '0 : (y == 0) ? x : x % y;
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [N-1:0] y);
    if (op == 4'd8) return N + 1;
    if (DIV_EN && (op == 4'd9 || op == 4'd10) && y != 0) return N + 1;
    return 1;
  endfunction

  // Issues one request, scrambles operands after accept and waits for done.
  task automatic run_op(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
    @(negedge clk);
    alu_control = op; a = x; b = y; start = 1'b1;
    prev_res = result;
    @(negedge clk);
    start = 1'b0; a = rnd64(); b = rnd64(); alu_control = 4'(op + 4'd1);
    lat = 1; busy_cycles = 0; overlap = 1'b0; res_moved = 1'b0;
    while (!done && lat < TMO) begin
      if (busy) busy_cycles++;
      if (result !== prev_res) res_moved = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (busy && done) overlap = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0; alu_control = '0;
    repeat (3) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done got=%b exp=0", done); else n_pass++;
    n_total++; if (result !== '0) $display("FAIL rst_result got=%0h exp=0", result); else n_pass++;
    n_total++; if (zero !== 1'b1) $display("FAIL rst_zero got=%b exp=1", zero); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single_cycle();
    logic [3:0]   codes [10] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd5, 4'd13, 4'd15};
    logic [3:0]   ops   [$];
    logic [N-1:0] xs    [$];
    logic [N-1:0] ys    [$];
    logic [N-1:0] exp;
    ops = '{4'd2, 4'd6, 4'd12};
    xs  = '{64'd5, 64'd42, 64'd0};
    ys  = '{64'd7, 64'd42, 64'd0};
    for (int i = 0; i < 16; i++) begin
      ops.push_back(codes[$urandom_range(0, 9)]);
      xs.push_back(rnd64());
      ys.push_back((i % 4 == 0) ? xs[xs.size()-1] : rnd64());
    end
    for (int i = 0; i < ops.size(); i++) begin
      exp = ref_result(ops[i], xs[i], ys[i]);
      run_op(ops[i], xs[i], ys[i]);
      n_total++; if (result !== exp) $display("FAIL sc_result op=%0d got=%0h exp=%0h", ops[i], result, exp); else n_pass++;
      n_total++; if (zero !== (exp == 0)) $display("FAIL sc_zero op=%0d got=%b exp=%b", ops[i], zero, exp == 0); else n_pass++;
      n_total++; if (lat != 1) $display("FAIL sc_latency op=%0d got=%0d exp=1", ops[i], lat); else n_pass++;
      n_total++; if (busy_cycles != 0) $display("FAIL sc_busy op=%0d got=%0d exp=0", ops[i], busy_cycles); else n_pass++;
    end
  endtask

  task automatic test_mul();
    logic [N-1:0] x, y, exp;
    // Directed product with a rival start pulse during the iteration.
    @(negedge clk);
    alu_control = 4'd8; a = 64'd123456; b = 64'd1000; start = 1'b1;
    prev_res = result;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_cycles = 0; res_moved = 1'b0;
    while (!done && lat < TMO) begin
      if (busy) busy_cycles++;
      if (result !== prev_res) res_moved = 1'b1;
      if (lat == 10) begin
        start = 1'b1; a = 64'd99; b = 64'd77; alu_control = 4'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_total++; if (result !== 64'd123456000) $display("FAIL mul_result got=%0d exp=123456000", result); else n_pass++;
    n_total++; if (lat != N + 1) $display("FAIL mul_latency got=%0d exp=%0d", lat, N + 1); else n_pass++;
    n_total++; if (busy_cycles != N) $display("FAIL mul_busy got=%0d exp=%0d", busy_cycles, N); else n_pass++;
    n_total++; if (res_moved !== 1'b0) $display("FAIL mul_hold got=%b exp=0", res_moved); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mul_busy_at_done got=%b exp=0", busy); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b0) $display("FAIL mul_done_pulse got=%b exp=0", done); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      x = rnd64(); y = (i == 0) ? 64'd0 : rnd64();
      exp = ref_result(4'd8, x, y);
      run_op(4'd8, x, y);
      n_total++; if (result !== exp) $display("FAIL mulr_result got=%0h exp=%0h", result, exp); else n_pass++;
      n_total++; if (zero !== (exp == 0)) $display("FAIL mulr_zero got=%b exp=%b", zero, exp == 0); else n_pass++;
      n_total++; if (lat != N + 1) $display("FAIL mulr_latency got=%0d exp=%0d", lat, N + 1); else n_pass++;
      n_total++; if (busy_cycles != N) $display("FAIL mulr_busy got=%0d exp=%0d", busy_cycles, N); else n_pass++;
      n_total++; if (overlap !== 1'b0) $display("FAIL mulr_overlap got=%b exp=0", overlap); else n_pass++;
    end
  endtask

  task automatic test_div();
    logic [3:0]   ops [$];
    logic [N-1:0] xs  [$];
    logic [N-1:0] ys  [$];
    logic [N-1:0] exp;
    int           exp_lat;
    ops = '{4'd9, 4'd10, 4'd9, 4'd10, 4'd9, 4'd10};
    xs  = '{64'd100, 64'd100, 64'd100, 64'd100, rnd64(), rnd64()};
    ys  = '{64'd7, 64'd7, 64'd0, 64'd0, 64'({$urandom} | 32'd1), rnd64() >> 8};
    for (int i = 0; i < ops.size(); i++) begin
      exp     = ref_result(ops[i], xs[i], ys[i]);
      exp_lat = ref_latency(ops[i], ys[i]);
      run_op(ops[i], xs[i], ys[i]);
      n_total++; if (result !== exp) $display("FAIL div_result op=%0d got=%0h exp=%0h", ops[i], result, exp); else n_pass++;
      n_total++; if (lat != exp_lat) $display("FAIL div_latency op=%0d got=%0d exp=%0d", ops[i], lat, exp_lat); else n_pass++;
      n_total++; if (busy_cycles != exp_lat - 1) $display("FAIL div_busy op=%0d got=%0d exp=%0d", ops[i], busy_cycles, exp_lat - 1); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    run_op(4'd2, 64'd3, 64'd4);
    n_total++; if (result !== 64'd7) $display("FAIL pre_rst_add got=%0d exp=7", result); else n_pass++;
    @(negedge clk);
    alu_control = 4'd8; a = 64'd5; b = 64'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_total++; if (busy !== 1'b1) $display("FAIL mid_busy got=%b exp=1", busy); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL arst_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL arst_done got=%b exp=0", done); else n_pass++;
    n_total++; if (result !== '0) $display("FAIL arst_result got=%0h exp=0", result); else n_pass++;
    n_total++; if (zero !== 1'b1) $display("FAIL arst_zero got=%b exp=1", zero); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL post_rst_idle got=%b%b exp=00", busy, done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] x1, y1, x2, y2;
    x1 = rnd64(); y1 = rnd64(); x2 = rnd64(); y2 = rnd64();
    @(negedge clk);
    alu_control = 4'd2; a = x1; b = y1; start = 1'b1;
    @(negedge clk);
    n_total++; if (done !== 1'b1) $display("FAIL b2b_done1 got=%b exp=1", done); else n_pass++;
    n_total++; if (result !== x1 + y1) $display("FAIL b2b_result1 got=%0h exp=%0h", result, x1 + y1); else n_pass++;
    a = x2; b = y2;
    @(negedge clk);
    start = 1'b0;
    n_total++; if (done !== 1'b1) $display("FAIL b2b_done2 got=%b exp=1", done); else n_pass++;
    n_total++; if (result !== x2 + y2) $display("FAIL b2b_result2 got=%0h exp=%0h", result, x2 + y2); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", done); else n_pass++;
    n_total++; if (result !== x2 + y2) $display("FAIL b2b_hold got=%0h exp=%0h", result, x2 + y2); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
